// File: rtl/breadboard_pkg.sv
// rtl/breadboard_pkg.sv - shared constants and state encoding for the breadboard sweeper
package breadboard_pkg;
  localparam int NUM_ROWS = 16;
  localparam int NUM_F    = 10;
  localparam int CSUM_W   = 14;

  localparam int BIT_W = 3;
  localparam int BIT_X = 2;
  localparam int BIT_Y = 1;
  localparam int BIT_Z = 0;

  typedef enum logic [1:0] {IDLE, WAIT, CAPT, FIN} state_e;
endpackage

// File: rtl/breadboard_sweeper_result_ram.sv
// rtl/breadboard_sweeper_result_ram.sv - 16x10 result table, one write port, registered read
module result_ram
  import breadboard_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [3:0]       wr_addr,
  input  logic [NUM_F-1:0] wr_data,
  input  logic [3:0]       rd_addr,
  output logic [NUM_F-1:0] rd_data
);
  logic [NUM_F-1:0] mem_q [NUM_ROWS];
  logic [NUM_F-1:0] rd_data_q;

  // Table contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_addr] <= wr_data;
  end

  // Non-blocking read of mem_q gives read-before-write on a same-row collision.
  always_ff @(posedge clk) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/breadboard_sweeper.sv
// rtl/breadboard_sweeper.sv - sweeps the breadboard through all 16 inputs and captures its outputs
module breadboard_sweeper #(
  parameter int SETTLE = 3,
  parameter int NUM_F  = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  output logic [3:0]                  bb_in,
  input  logic [NUM_F-1:0]            bb_f,
  output logic                        busy,
  output logic                        done,
  output logic                        table_valid,
  output logic [breadboard_pkg::CSUM_W-1:0] checksum,
  input  logic [3:0]                  rd_addr,
  output logic [NUM_F-1:0]            rd_data
);
  import breadboard_pkg::*;

  localparam logic [3:0] SETTLE_V = 4'(SETTLE);
  localparam logic [3:0] LAST_ROW = 4'(NUM_ROWS - 1);

  state_e            state_q;
  logic [3:0]        idx_q;
  logic [3:0]        bb_in_q;
  logic [3:0]        cnt_q;
  logic              busy_q;
  logic              done_q;
  logic              tv_q;
  logic [CSUM_W-1:0] csum_q;
  logic [CSUM_W-1:0] csum_d;
  logic              we_d;

  assign csum_d = csum_q + CSUM_W'(bb_f);
  assign we_d   = (state_q == CAPT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      bb_in_q <= '0;
      cnt_q   <= SETTLE_V;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tv_q    <= 1'b0;
      csum_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_q <= WAIT;
            idx_q   <= '0;
            bb_in_q <= '0;
            cnt_q   <= SETTLE_V;
            csum_q  <= '0;
            tv_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == 4'd1) begin
            state_q <= CAPT;
          end
        end
        CAPT: begin
          // The capture itself is not cancelled by a coincident abort.
          csum_q <= csum_d;
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (idx_q == LAST_ROW) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            tv_q    <= 1'b1;
          end else begin
            state_q <= WAIT;
            idx_q   <= idx_q + 4'd1;
            bb_in_q <= idx_q + 4'd1;
            cnt_q   <= SETTLE_V;
          end
        end
        FIN: begin
          state_q <= IDLE;
          if (abort) tv_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  result_ram u_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (we_d),
    .wr_addr (idx_q),
    .wr_data (bb_f),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign bb_in       = bb_in_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign table_valid = tv_q;
  assign checksum    = csum_q;
endmodule

// File: tb/tb_breadboard_sweeper.sv
// tb/tb_breadboard_sweeper.sv - scoreboard bench for breadboard_sweeper at SETTLE 1, 3 and 15
module tb_breadboard_sweeper;
  localparam logic [9:0] BB_TBL [16] = '{
    10'h194, 10'h0a7, 10'h31c, 10'h2e1, 10'h05b, 10'h3c8, 10'h112, 10'h27d,
    10'h0f0, 10'h1e9, 10'h34a, 10'h086, 10'h2b5, 10'h15f, 10'h3a3, 10'h266};

  logic        clk = 1'b0;
  logic        reset, start, abort, start_aux, use_ff;
  logic [3:0]  rd_addr;
  logic [3:0]  bb_in, bb_in1, bb_in15;
  logic [9:0]  bb_f, bb_f1, bb_f15;
  logic        busy, done, tv;
  logic        busy1, done1, tv1, busy15, done15, tv15;
  logic [13:0] checksum, cs1, cs15;
  logic [9:0]  rd_data, rd1, rd15;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_mem [16];
  logic [9:0] exp_q [$];

  always #5 clk = ~clk;

  assign bb_f   = use_ff ? 10'h3FF : BB_TBL[bb_in];
  assign bb_f1  = BB_TBL[bb_in1];
  assign bb_f15 = BB_TBL[bb_in15];

  breadboard_sweeper #(.SETTLE(3), .NUM_F(10)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .bb_in(bb_in), .bb_f(bb_f),
    .busy(busy), .done(done), .table_valid(tv), .checksum(checksum),
    .rd_addr(rd_addr), .rd_data(rd_data));

  breadboard_sweeper #(.SETTLE(1), .NUM_F(10)) dut1 (
    .clk(clk), .reset(reset), .start(start_aux), .abort(1'b0), .bb_in(bb_in1), .bb_f(bb_f1),
    .busy(busy1), .done(done1), .table_valid(tv1), .checksum(cs1),
    .rd_addr(4'd0), .rd_data(rd1));

  breadboard_sweeper #(.SETTLE(15), .NUM_F(10)) dut15 (
    .clk(clk), .reset(reset), .start(start_aux), .abort(1'b0), .bb_in(bb_in15), .bb_f(bb_f15),
    .busy(busy15), .done(done15), .table_valid(tv15), .checksum(cs15),
    .rd_addr(4'd0), .rd_data(rd15));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic readback(input int lo, input int hi);
    for (int a = lo; a <= hi + 1; a++) begin
      @(negedge clk);
      if (a > lo) chk($sformatf("row%0d", a - 1), 32'(rd_data), 32'(exp_q.pop_front()));
      if (a <= hi) begin
        rd_addr = 4'(a);
        exp_q.push_back(exp_mem[a]);
      end
    end
  endtask

  task automatic sweep(input int abort_at, input int reset_at, output int dcyc, output int dcnt);
    dcyc = -1;
    dcnt = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      reset = 1'b0;
      if (done) begin
        dcnt++;
        if (dcyc < 0) dcyc = c;
      end
      if (c == abort_at + 1) begin
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_bb_in", 32'(bb_in), 32'd4);
      end
      if (c == reset_at + 1) begin
        chk("rst_bb_in", 32'(bb_in), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tv", 32'(tv), 32'd0);
        chk("rst_csum", 32'(checksum), 32'd0);
        chk("rst_rd", 32'(rd_data), 32'd0);
      end
      if (c == abort_at) abort = 1'b1;
      if (c == reset_at) reset = 1'b1;
    end
  endtask

  initial begin
    int exp_sum, part_sum, dcyc, dcnt;
    int d1, d3, d15, n1, n3, n15, busy_err, per1, per3, per15;
    logic tv65;
    logic [13:0] cs65;

    exp_sum = 0;
    part_sum = 0;
    for (int i = 0; i < 16; i++) begin
      exp_sum += int'(BB_TBL[i]);
      if (i < 5) part_sum += int'(BB_TBL[i]);
    end

    reset = 1'b1; start = 1'b0; abort = 1'b0; start_aux = 1'b0; use_ff = 1'b0; rd_addr = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_bb_in", 32'(bb_in), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_tv", 32'(tv), 32'd0);
    chk("reset_csum", 32'(checksum), 32'd0);
    chk("reset_rd", 32'(rd_data), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Three settle times in parallel; start pulses on the main unit mid-sweep must be ignored.
    d1 = -1; d3 = -1; d15 = -1; n1 = 0; n3 = 0; n15 = 0;
    busy_err = 0; per1 = 0; per3 = 0; per15 = 0; tv65 = 1'b0; cs65 = '0;
    start = 1'b1;
    start_aux = 1'b1;
    for (int c = 1; c <= 262; c++) begin
      @(negedge clk);
      start_aux = 1'b0;
      start = (c == 10 || c == 11 || c == 40);
      if (done)   begin n3++;  if (d3 < 0)  d3 = c;  end
      if (done1)  begin n1++;  if (d1 < 0)  d1 = c;  end
      if (done15) begin n15++; if (d15 < 0) d15 = c; end
      if (c <= 80 && busy !== (c <= 64)) busy_err++;
      if (32'(bb_in)   !== 32'(((c - 1) / 4)  > 15 ? 15 : (c - 1) / 4))  per3++;
      if (32'(bb_in1)  !== 32'(((c - 1) / 2)  > 15 ? 15 : (c - 1) / 2))  per1++;
      if (32'(bb_in15) !== 32'(((c - 1) / 16) > 15 ? 15 : (c - 1) / 16)) per15++;
      if (c == 65) begin
        tv65 = tv;
        cs65 = checksum;
      end
    end
    chk("done_cyc_s3", 32'(d3), 32'd65);
    chk("done_cyc_s1", 32'(d1), 32'd33);
    chk("done_cyc_s15", 32'(d15), 32'd257);
    chk("done_cnt_s3", 32'(n3), 32'd1);
    chk("done_cnt_s1", 32'(n1), 32'd1);
    chk("done_cnt_s15", 32'(n15), 32'd1);
    chk("busy_profile", 32'(busy_err), 32'd0);
    chk("bb_in_step_s3", 32'(per3), 32'd0);
    chk("bb_in_step_s1", 32'(per1), 32'd0);
    chk("bb_in_step_s15", 32'(per15), 32'd0);
    chk("tv_at_done", 32'(tv65), 32'd1);
    chk("csum_at_done", 32'(cs65), 32'(exp_sum));
    chk("csum_s1", 32'(cs1), 32'(exp_sum));
    chk("csum_s15", 32'(cs15), 32'(exp_sum));
    for (int i = 0; i < 16; i++) exp_mem[i] = BB_TBL[i];
    readback(0, 15);

    use_ff = 1'b1;
    sweep(-10, -10, dcyc, dcnt);
    chk("ff_done_cyc", 32'(dcyc), 32'd65);
    chk("ff_csum", 32'(checksum), 32'd16368);
    chk("ff_tv", 32'(tv), 32'd1);
    for (int i = 0; i < 16; i++) exp_mem[i] = 10'h3FF;
    readback(0, 2);

    use_ff = 1'b0;
    sweep(20, -10, dcyc, dcnt);
    chk("abort_done_cnt", 32'(dcnt), 32'd0);
    chk("abort_tv", 32'(tv), 32'd0);
    chk("abort_csum", 32'(checksum), 32'(part_sum));
    for (int i = 0; i < 5; i++) exp_mem[i] = BB_TBL[i];
    readback(0, 5);

    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("sa_busy", 32'(busy), 32'd0);
    end
    chk("sa_bb_in", 32'(bb_in), 32'd4);
    sweep(-10, -10, dcyc, dcnt);
    chk("post_abort_done", 32'(dcyc), 32'd65);
    chk("post_abort_csum", 32'(checksum), 32'(exp_sum));

    sweep(-10, 30, dcyc, dcnt);
    chk("rst_done_cnt", 32'(dcnt), 32'd0);
    sweep(-10, -10, dcyc, dcnt);
    chk("post_rst_done", 32'(dcyc), 32'd65);
    chk("post_rst_csum", 32'(checksum), 32'(exp_sum));
    chk("post_rst_tv", 32'(tv), 32'd1);
    for (int i = 0; i < 16; i++) exp_mem[i] = BB_TBL[i];
    readback(0, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
